// File: rtl/vx_decode_warp_sched.sv
// Per-warp decode FIFOs feeding a round-robin issue scheduler. A full warp FIFO
// back-pressures only its own warp, and a presented instruction is held until issue takes it.
module vx_decode_warp_sched #(
    parameter int NUM_WARPS = 4,
    parameter int NW_BITS   = 2,
    parameter int DEPTH     = 2,
    parameter int DATA_W    = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dec_valid,
    input  logic [NW_BITS-1:0]   dec_wid,
    input  logic [DATA_W-1:0]    dec_data,
    output logic                 dec_ready,
    input  logic [NUM_WARPS-1:0] stall_mask,
    output logic                 iss_valid,
    output logic [NW_BITS-1:0]   iss_wid,
    output logic [DATA_W-1:0]    iss_data,
    input  logic                 iss_ready,
    output logic [NUM_WARPS-1:0] warp_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_UNLOCKED = 1'b0, S_LOCKED = 1'b1} state_t;

    logic [DATA_W-1:0]    r_mem    [NUM_WARPS][DEPTH];
    logic [CNT_W-1:0]     r_count  [NUM_WARPS];
    logic [PTR_W-1:0]     r_wr_ptr [NUM_WARPS];
    logic [PTR_W-1:0]     r_rd_ptr [NUM_WARPS];
    logic [NW_BITS-1:0]   r_rr_ptr;
    logic [NW_BITS-1:0]   r_locked_wid;
    state_t               r_state;

    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_push;
    logic [NUM_WARPS-1:0] w_pop;
    logic                 w_grant_vld;
    logic [NW_BITS-1:0]   w_grant_wid;
    logic [NW_BITS-1:0]   w_cand;
    logic                 w_fire_in;
    logic                 w_fire_out;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_elig[w]    = (r_count[w] != '0) & ~stall_mask[w];
            warp_full[w] = (r_count[w] == CNT_W'(DEPTH));
            w_push[w]    = w_fire_in  & (dec_wid == NW_BITS'(w));
            w_pop[w]     = w_fire_out & (iss_wid == NW_BITS'(w));
        end
    end

    // Round-robin scan starts just after the last warp that issued.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_wid = '0;
        w_cand      = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            w_cand = r_rr_ptr + NW_BITS'(i);
            if (!w_grant_vld && w_elig[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_wid = w_cand;
            end
        end
    end

    // A held offer ignores the stall mask so the presented instruction never retracts.
    assign iss_valid  = (r_state == S_LOCKED) | w_grant_vld;
    assign iss_wid    = (r_state == S_LOCKED) ? r_locked_wid : w_grant_wid;
    assign iss_data   = r_mem[iss_wid][r_rd_ptr[iss_wid]];
    assign dec_ready  = (r_count[dec_wid] != CNT_W'(DEPTH));
    assign w_fire_in  = dec_valid & dec_ready;
    assign w_fire_out = iss_valid & iss_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_count[w]  <= '0;
                r_wr_ptr[w] <= '0;
                r_rd_ptr[w] <= '0;
            end
            r_rr_ptr     <= NW_BITS'(NUM_WARPS - 1);
            r_locked_wid <= '0;
            r_state      <= S_UNLOCKED;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_push[w]) r_wr_ptr[w] <= ptr_inc(r_wr_ptr[w]);
                if (w_pop[w])  r_rd_ptr[w] <= ptr_inc(r_rd_ptr[w]);
                if (w_push[w] && !w_pop[w])
                    r_count[w] <= r_count[w] + CNT_W'(1);
                else if (w_pop[w] && !w_push[w])
                    r_count[w] <= r_count[w] - CNT_W'(1);
            end
            if (w_fire_out) r_rr_ptr <= iss_wid;
            case (r_state)
                S_UNLOCKED: begin
                    if (iss_valid && !iss_ready) begin
                        r_state      <= S_LOCKED;
                        r_locked_wid <= iss_wid;
                    end
                end
                S_LOCKED: begin
                    if (iss_ready) r_state <= S_UNLOCKED;
                end
                default: r_state <= S_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire_in) r_mem[dec_wid][r_wr_ptr[dec_wid]] <= dec_data;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_fire_in && r_count[dec_wid] == CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_fire_out && r_count[iss_wid] == '0));

endmodule

// File: tb/tb_vx_decode_warp_sched.sv
// Bench for vx_decode_warp_sched: directed scenarios plus random traffic against a
// queue-based reference model, with a scoreboard of issued instructions.
module tb_vx_decode_warp_sched;

    localparam int NW    = 4;
    localparam int DEPTH = 2;

    logic         clk;
    logic         reset_n;
    logic         dec_valid;
    logic [1:0]   dec_wid;
    logic [127:0] dec_data;
    logic         dec_ready;
    logic [3:0]   stall_mask;
    logic         iss_valid;
    logic [1:0]   iss_wid;
    logic [127:0] iss_data;
    logic         iss_ready;
    logic [3:0]   warp_full;

    int n_cmp = 0;
    int n_err = 0;

    vx_decode_warp_sched #(.NUM_WARPS(NW), .NW_BITS(2), .DEPTH(DEPTH), .DATA_W(128)) dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid(dec_valid), .dec_wid(dec_wid), .dec_data(dec_data), .dec_ready(dec_ready),
        .stall_mask(stall_mask),
        .iss_valid(iss_valid), .iss_wid(iss_wid), .iss_data(iss_data), .iss_ready(iss_ready),
        .warp_full(warp_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] w, input logic [127:0] d,
                         input logic [3:0] s, input logic r);
        dec_valid  = v;
        dec_wid    = w;
        dec_data   = d;
        stall_mask = s;
        iss_ready  = r;
    endtask

    // Reference model: one queue per warp, a last-issued warp index and a hold flag.
    logic [127:0] mq [NW][$];
    logic [129:0] sbq[$];
    int           m_rr   = NW - 1;
    bit           m_lock = 0;
    int           m_lwid = 0;

    always @(negedge clk) begin
        bit           ev;
        int           ew;
        bit           exp_dr;
        logic [127:0] ed;
        logic [3:0]   exp_full;
        #2;
        if (!reset_n) begin
            for (int w = 0; w < NW; w++) mq[w].delete();
            sbq.delete();
            m_rr   = NW - 1;
            m_lock = 0;
            m_lwid = 0;
            chk("rst_iss_valid", iss_valid, 0);
            chk("rst_dec_ready", dec_ready, 1);
            chk("rst_warp_full", warp_full, 0);
        end else begin
            exp_dr = (mq[dec_wid].size() < DEPTH);
            for (int w = 0; w < NW; w++) exp_full[w] = (mq[w].size() == DEPTH);
            ev = 0;
            ew = 0;
            if (m_lock) begin
                ev = 1;
                ew = m_lwid;
            end else begin
                for (int k = 1; k <= NW; k++) begin
                    int w;
                    w = (m_rr + k) % NW;
                    if (!ev && mq[w].size() != 0 && !stall_mask[w]) begin
                        ev = 1;
                        ew = w;
                    end
                end
            end
            ed = (ev && mq[ew].size() != 0) ? mq[ew][0] : '0;
            chk("iss_valid", iss_valid, ev);
            chk("dec_ready", dec_ready, exp_dr);
            chk("warp_full", warp_full, exp_full);
            if (ev) begin
                chk("iss_wid", iss_wid, ew);
                chk("iss_data", iss_data, ed);
            end
            if (ev && iss_ready) begin
                sbq.push_back({ew[1:0], ed});
                void'(mq[ew].pop_front());
                m_rr   = ew;
                m_lock = 0;
            end else if (ev) begin
                m_lock = 1;
                m_lwid = ew;
            end
            if (dec_valid && exp_dr) mq[dec_wid].push_back(dec_data);
        end
    end

    // Monitor: every accepted issue must match the oldest scoreboard entry.
    always @(negedge clk) begin
        logic [129:0] e;
        #3;
        if (reset_n && iss_valid && iss_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got issue wid %0d data %0h, expected none", iss_wid, iss_data);
            end else begin
                e = sbq.pop_front();
                chk("sb_wid", iss_wid, e[129:128]);
                chk("sb_data", iss_data, e[127:0]);
            end
        end
    end

    task automatic do_reset;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_iss_valid", iss_valid, 0);
        chk("async_dec_ready", dec_ready, 1);
        chk("async_warp_full", warp_full, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset release
        repeat (4) begin
            drive(0, 0, 0, 0, 1);
            #1;
            chk("idle_iss_valid", iss_valid, 0);
            chk("idle_dec_ready", dec_ready, 1);
            chk("idle_warp_full", warp_full, 0);
            @(negedge clk);
        end

        // Single push, visible one cycle later
        drive(1, 2, 128'hA5, 0, 1);
        #1 chk("t2_same_cycle_valid", iss_valid, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        #1;
        chk("t2_valid", iss_valid, 1);
        chk("t2_wid", iss_wid, 2);
        chk("t2_data", iss_data, 128'hA5);
        @(negedge clk);
        #1 chk("t2_popped", iss_valid, 0);
        @(negedge clk);

        // Round-robin order over preloaded warps
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 2'(k % 4), 128'h300 + 128'(k), 0, 0);
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1);
            #1;
            chk("t3_wid", iss_wid, k % 4);
            chk("t3_data", iss_data, 128'h300 + 128'(k));
            @(negedge clk);
        end

        // Full warp stalls only itself
        do_reset();
        drive(1, 1, 128'h401, 4'hF, 0); @(negedge clk);
        drive(1, 1, 128'h402, 4'hF, 0); @(negedge clk);
        drive(1, 1, 128'h403, 4'hF, 0);
        #1;
        chk("t4_full_ready", dec_ready, 0);
        chk("t4_full_flag", warp_full, 4'b0010);
        @(negedge clk);
        drive(1, 3, 128'h404, 4'hF, 0);
        #1 chk("t4_other_ready", dec_ready, 1);
        @(negedge clk);
        drive(0, 0, 0, 4'hF, 0);
        #1 chk("t4_flags_after", warp_full, 4'b0010);
        @(negedge clk);
        repeat (6) begin drive(0, 0, 0, 0, 1); @(negedge clk); end

        // Held offer survives stall_mask rising
        do_reset();
        drive(1, 0, 128'hD0, 0, 0); @(negedge clk);
        drive(1, 1, 128'hD1, 0, 0);
        #1 chk("t5_hold0_wid", iss_wid, 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 4'b0001, 0);
            #1;
            chk("t5_hold_valid", iss_valid, 1);
            chk("t5_hold_wid", iss_wid, 0);
            chk("t5_hold_data", iss_data, 128'hD0);
            @(negedge clk);
        end
        drive(0, 0, 0, 4'b0001, 1);
        #1 chk("t5_fire_wid", iss_wid, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        #1;
        chk("t5_next_wid", iss_wid, 1);
        chk("t5_next_data", iss_data, 128'hD1);
        @(negedge clk);

        // Stall mask leaves only warp 2, then async reset mid-stream
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'(k), 128'h600 + 128'(k), 4'hF, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 4'b1011, 1);
        #1;
        chk("t6_valid", iss_valid, 1);
        chk("t6_wid", iss_wid, 2);
        chk("t6_data", iss_data, 128'h602);
        @(negedge clk);
        drive(0, 0, 0, 4'b1011, 1);
        #1 chk("t6_others_blocked", iss_valid, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] s;
            if (i == 700) do_reset();
            for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom, $urandom, $urandom}, s,
                  ($urandom_range(0, 9) < 7));
            @(negedge clk);
        end

        repeat (12) begin drive(0, 0, 0, 0, 1); @(negedge clk); end
        #4 chk("sb_drained", 128'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
